sub_share_arbiter: RTL

//   Shares one top_sub absolute-difference datapath between N requesters.

---
 rtl/sub_share_pkg.sv | 33 +++
 rtl/top_sub.sv | 22 ++
 rtl/sub_share_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sub_share_pkg.sv
// Shared types and helpers for the subtractor-sharing arbiter.
package sub_share_pkg;

   // Arbiter FSM: idle, one-cycle execute, hold result until the owner releases.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   // Upper bound on requesters handled by rr_pick; the request vector is
   // zero-extended to this width so one function serves every N.
   localparam int MAX_N = 32;

   // Round-robin winner: first requester with its bit set, scanning
   // ptr, ptr+1, ... modulo n. Returns 0 when nothing is requesting.
   function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
      int  idx;
      bit  found;
      rr_pick = 0;
      found   = 1'b0;
      for (int k = 0; k < MAX_N; k++) begin
         if (k < n && !found) begin
            idx = (ptr + k) % n;
            if (req[5'(idx)]) begin
               rr_pick = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/top_sub.sv
// Unsigned absolute-difference unit: r = |a - b - cin|, ne flags a negative
// raw difference, cout is the carry (no-borrow) out of the subtraction.
module top_sub #(
   parameter int x = 4
) (
   input  logic [x-1:0] a,
   input  logic [x-1:0] b,
   input  logic         cin,
   output logic [x-1:0] r,
   output logic         ne,
   output logic         cout
);

   logic [x:0] diff;

   // One extra bit captures the borrow; a borrow means the result must be negated.
   assign diff = {1'b0, a} - {1'b0, b} - {{x{1'b0}}, cin};
   assign ne   = diff[x];
   assign cout = ~diff[x];
   assign r    = diff[x] ? (~diff[x-1:0] + 1'b1) : diff[x-1:0];

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter sharing a single top_sub among N requesters.
// Operands are captured on the grant edge; the result is registered on the
// exit from EXEC and held until the owner drops its request.
module sub_share_arbiter
   import sub_share_pkg::*;
#(
   parameter  int X  = 4,
   parameter  int N  = 2,
   localparam int OW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*X-1:0]  a_in,
   input  logic [N*X-1:0]  b_in,
   output logic [N-1:0]    gnt,
   output logic            done,
   output logic [OW-1:0]   owner,
   output logic [X-1:0]    r_out,
   output logic            ne_out
);

   arb_state_t      state_reg,  state_next;
   logic [N-1:0]    gnt_reg,    gnt_next;
   logic            done_reg,   done_next;
   logic [OW-1:0]   owner_reg,  owner_next;
   logic [OW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [X-1:0]    op_a_reg,   op_a_next;
   logic [X-1:0]    op_b_reg,   op_b_next;
   logic [X-1:0]    r_out_reg,  r_out_next;
   logic            ne_reg,     ne_next;

   logic [MAX_N-1:0] req_ext;
   int               pick_idx;
   logic [X-1:0]     sub_r;
   logic             sub_ne;

   assign req_ext  = MAX_N'(req);
   assign pick_idx = rr_pick(req_ext, int'(rr_ptr_reg), N);

   // The shared datapath always works on the latched operand copy.
   top_sub #(.x(X)) u_sub (
      .a    (op_a_reg),
      .b    (op_b_reg),
      .cin  (1'b0),
      .r    (sub_r),
      .ne   (sub_ne),
      .cout ()
   );

   // Next-state and register-update logic; everything holds unless a state acts on it.
   always_comb begin
      state_next  = state_reg;
      gnt_next    = gnt_reg;
      done_next   = done_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      op_a_next   = op_a_reg;
      op_b_next   = op_b_reg;
      r_out_next  = r_out_reg;
      ne_next     = ne_reg;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               gnt_next   = N'(1) << pick_idx;
               owner_next = OW'(pick_idx);
               op_a_next  = a_in[pick_idx*X +: X];
               op_b_next  = b_in[pick_idx*X +: X];
               state_next = EXEC;
            end
         end
         EXEC: begin
            r_out_next = sub_r;
            ne_next    = sub_ne;
            done_next  = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            if (!req[owner_reg]) begin
               gnt_next    = '0;
               done_next   = 1'b0;
               rr_ptr_next = (int'(owner_reg) + 1 == N) ? '0 : owner_reg + 1'b1;
               state_next  = IDLE;
            end
         end
         default: begin
            gnt_next   = '0;
            done_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         gnt_reg    <= '0;
         done_reg   <= 1'b0;
         owner_reg  <= '0;
         rr_ptr_reg <= '0;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
         r_out_reg  <= '0;
         ne_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         gnt_reg    <= gnt_next;
         done_reg   <= done_next;
         owner_reg  <= owner_next;
         rr_ptr_reg <= rr_ptr_next;
         op_a_reg   <= op_a_next;
         op_b_reg   <= op_b_next;
         r_out_reg  <= r_out_next;
         ne_reg     <= ne_next;
      end
   end

   assign gnt    = gnt_reg;
   assign done   = done_reg;
   assign owner  = owner_reg;
   assign r_out  = r_out_reg;
   assign ne_out = ne_reg;

endmodule
